// File: rtl/watch_pkg.sv
// Shared widths, range limits, alarm channel states and time arithmetic
// used by the multi-alarm watch and its alarm channels.
package watch_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] MAX_SEC = SEC_W'(59);
  localparam logic [MIN_W-1:0] MAX_MIN = MIN_W'(59);
  localparam logic [HR_W-1:0]  MAX_HR  = HR_W'(23);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

  typedef struct packed {
    logic [HR_W-1:0]  hours;
    logic [MIN_W-1:0] minutes;
  } hm_t;

  // hours:minutes + delta minutes, wrapped modulo 24 h
  function automatic hm_t add_minutes(input logic [HR_W-1:0] hours,
                                      input logic [MIN_W-1:0] minutes,
                                      input int delta);
    int  total;
    hm_t res;
    total       = (int'(hours) * 60 + int'(minutes) + delta) % 1440;
    res.hours   = HR_W'(total / 60);
    res.minutes = MIN_W'(total % 60);
    return res;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: target registers, IDLE/RINGING/SNOOZED state machine,
// snooze target and ring-duration timer.
module alarm_channel
  import watch_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [HR_W-1:0]  wr_hours,
  input  logic [MIN_W-1:0] wr_minutes,
  input  logic             wr_enable,
  input  logic             sec_tick,
  input  logic             tick_late,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic             snooze,
  input  logic             dismiss,
  output logic             ringing
);

  localparam logic [7:0] RING_LOAD = 8'(RING_SEC);

  alarm_state_t state_reg, state_next;
  hm_t          alarm_reg, snz_reg, snz_next, target;
  logic         enable_reg;
  logic [7:0]   timer_reg, timer_next;
  logic         hit;

  assign target  = (state_reg == SNOOZED) ? snz_reg : alarm_reg;
  // The clock reached hh:mm:00 one cycle ago; loads never produce tick_late
  assign hit     = tick_late && (cur_sec == '0) &&
                   (cur_hr == target.hours) && (cur_min == target.minutes);
  assign ringing = (state_reg == RINGING);

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    snz_next   = snz_reg;
    case (state_reg)
      IDLE: begin
        if (hit && enable_reg) begin
          state_next = RINGING;
          timer_next = RING_LOAD;
        end
      end
      RINGING: begin
        if (dismiss) begin
          state_next = IDLE;
        end else if (snooze) begin
          state_next = SNOOZED;
          snz_next   = add_minutes(cur_hr, cur_min, SNOOZE_MIN);
        end else if (sec_tick) begin
          timer_next = timer_reg - 8'd1;
          if (timer_reg <= 8'd1) state_next = IDLE;
        end
      end
      SNOOZED: begin
        if (dismiss) begin
          state_next = IDLE;
        end else if (hit) begin
          state_next = RINGING;
          timer_next = RING_LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
    // A register write always returns the channel to IDLE, beating any trigger
    if (wr_en) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      snz_reg    <= '0;
      alarm_reg  <= '0;
      enable_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      snz_reg   <= snz_next;
      if (wr_en) begin
        alarm_reg.hours   <= wr_hours;
        alarm_reg.minutes <= wr_minutes;
        enable_reg        <= wr_enable;
      end
    end
  end

endmodule

// File: rtl/multi_alarm_watch.sv
// Time-of-day core: seconds prescaler, HH:MM:SS counters, NUM_ALARMS alarm
// channels and the blink divider for the alarm LED.
module multi_alarm_watch
  import watch_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int NUM_ALARMS = 4,
  parameter int FLASH_HALF = 12_500_000,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  localparam int AW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HR_W-1:0]       hours_init,
  input  logic                  set_en,
  input  logic [HR_W-1:0]       set_hours,
  input  logic [MIN_W-1:0]      set_minutes,
  input  logic [SEC_W-1:0]      set_seconds,
  input  logic                  alarm_we,
  input  logic [AW-1:0]         alarm_idx,
  input  logic [HR_W-1:0]       alarm_hours,
  input  logic [MIN_W-1:0]      alarm_minutes,
  input  logic                  alarm_enable,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [SEC_W-1:0]      second_count,
  output logic [MIN_W-1:0]      minute_count,
  output logic [HR_W-1:0]       hour_count,
  output logic                  sec_tick,
  output logic [NUM_ALARMS-1:0] alarm_active,
  output logic                  alarm_flash
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  logic [PW-1:0]    presc_reg;
  logic [SEC_W-1:0] sec_reg;
  logic [MIN_W-1:0] min_reg;
  logic [HR_W-1:0]  hr_reg;
  logic [HR_W-1:0]  init_hr;
  logic             tick_late_reg;
  logic             tick, set_ok, wr_ok, any_ring;
  logic [FW-1:0]    flash_cnt_reg;
  logic             flash_phase_reg;

  assign init_hr = (hours_init > MAX_HR) ? '0 : hours_init;
  assign set_ok  = set_en && (set_hours <= MAX_HR) &&
                   (set_minutes <= MAX_MIN) && (set_seconds <= MAX_SEC);
  assign wr_ok   = alarm_we && (alarm_hours <= MAX_HR) &&
                   (alarm_minutes <= MAX_MIN) && (int'(alarm_idx) < NUM_ALARMS);
  assign tick     = (presc_reg == PRESC_LAST);
  assign sec_tick = tick && !set_ok;

  assign second_count = sec_reg;
  assign minute_count = min_reg;
  assign hour_count   = hr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg     <= '0;
      sec_reg       <= '0;
      min_reg       <= '0;
      hr_reg        <= init_hr;
      tick_late_reg <= 1'b0;
    end else begin
      tick_late_reg <= sec_tick;
      if (set_ok) begin
        presc_reg <= '0;
        sec_reg   <= set_seconds;
        min_reg   <= set_minutes;
        hr_reg    <= set_hours;
      end else if (tick) begin
        presc_reg <= '0;
        if (sec_reg == MAX_SEC) begin
          sec_reg <= '0;
          if (min_reg == MAX_MIN) begin
            min_reg <= '0;
            hr_reg  <= (hr_reg == MAX_HR) ? '0 : hr_reg + HR_W'(1);
          end else begin
            min_reg <= min_reg + MIN_W'(1);
          end
        end else begin
          sec_reg <= sec_reg + SEC_W'(1);
        end
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_chan
      alarm_channel #(
        .SNOOZE_MIN (SNOOZE_MIN),
        .RING_SEC   (RING_SEC)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_ok && (alarm_idx == AW'(gi))),
        .wr_hours   (alarm_hours),
        .wr_minutes (alarm_minutes),
        .wr_enable  (alarm_enable),
        .sec_tick   (sec_tick),
        .tick_late  (tick_late_reg),
        .cur_sec    (sec_reg),
        .cur_min    (min_reg),
        .cur_hr     (hr_reg),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .ringing    (alarm_active[gi])
      );
    end
  endgenerate

  // Blink phase runs only while something rings, so a newly joining channel
  // inherits the current phase instead of restarting it.
  assign any_ring    = |alarm_active;
  assign alarm_flash = any_ring && !flash_phase_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt_reg   <= '0;
      flash_phase_reg <= 1'b0;
    end else if (!any_ring) begin
      flash_cnt_reg   <= '0;
      flash_phase_reg <= 1'b0;
    end else if (flash_cnt_reg == FLASH_LAST) begin
      flash_cnt_reg   <= '0;
      flash_phase_reg <= !flash_phase_reg;
    end else begin
      flash_cnt_reg   <= flash_cnt_reg + FW'(1);
    end
  end

endmodule

// File: tb/tb_multi_alarm_watch.sv
// Scoreboard bench for multi_alarm_watch: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_multi_alarm_watch;
  localparam int TICK_DIV   = 4;
  localparam int NUM_ALARMS = 2;
  localparam int FLASH_HALF = 2;
  localparam int SNOOZE_MIN = 5;
  localparam int RING_SEC   = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] hours_init;
  logic       set_en;
  logic [4:0] set_hours;
  logic [5:0] set_minutes, set_seconds;
  logic       alarm_we;
  logic [0:0] alarm_idx;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_enable, snooze, dismiss;
  logic [5:0] second_count, minute_count;
  logic [4:0] hour_count;
  logic       sec_tick, alarm_flash;
  logic [1:0] alarm_active;

  multi_alarm_watch #(
    .TICK_DIV(TICK_DIV), .NUM_ALARMS(NUM_ALARMS), .FLASH_HALF(FLASH_HALF),
    .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)
  ) dut (
    .clk(clk), .reset(reset), .hours_init(hours_init),
    .set_en(set_en), .set_hours(set_hours), .set_minutes(set_minutes),
    .set_seconds(set_seconds), .alarm_we(alarm_we), .alarm_idx(alarm_idx),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .alarm_enable(alarm_enable), .snooze(snooze), .dismiss(dismiss),
    .second_count(second_count), .minute_count(minute_count),
    .hour_count(hour_count), .sec_tick(sec_tick),
    .alarm_active(alarm_active), .alarm_flash(alarm_flash)
  );

  always #5 clk = ~clk;

  typedef enum int {K_TIME, K_TICK, K_ACT, K_FLASH} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [16:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int off, input kind_t k, input logic [16:0] v,
                           input string nm);
    exp_t e;
    int   i;
    e.cyc = cyc + off; e.kind = k; e.val = v; e.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= e.cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic exp_time(input int off, input int h, input int m, input int s,
                          input string nm);
    expect_at(off, K_TIME, {5'(h), 6'(m), 6'(s)}, nm);
  endtask
  task automatic exp_tick(input int off, input int v, input string nm);
    expect_at(off, K_TICK, 17'(v), nm);
  endtask
  task automatic exp_act(input int off, input int v, input string nm);
    expect_at(off, K_ACT, 17'(v), nm);
  endtask
  task automatic exp_flash(input int off, input int v, input string nm);
    expect_at(off, K_FLASH, 17'(v), nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_set(input int h, input int m, input int s);
    set_hours = 5'(h); set_minutes = 6'(m); set_seconds = 6'(s);
    set_en = 1'b1;
    step(1);
    set_en = 1'b0;
  endtask

  task automatic wr_alarm(input int idx, input int h, input int m, input bit en);
    alarm_idx = 1'(idx); alarm_hours = 5'(h); alarm_minutes = 6'(m);
    alarm_enable = en; alarm_we = 1'b1;
    step(1);
    alarm_we = 1'b0;
  endtask

  // Monitor: compare every expectation due this cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_TIME:  act = {hour_count, minute_count, second_count};
        K_TICK:  act = {16'd0, sec_tick};
        K_ACT:   act = {15'd0, alarm_active};
        default: act = {16'd0, alarm_flash};
      endcase
      total++;
      if (e.cyc != cyc || act !== e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d due=%0d got=%0h want=%0h", e.name, cyc, e.cyc, act, e.val);
      end else begin
        $display("ok   %s cyc=%0d value=%0h", e.name, cyc, act);
      end
    end
    if (done) begin
      while (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL %s never checked got=none want=%0h", e.name, e.val);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hours_init = 5'd30;
    set_en = 0; set_hours = 0; set_minutes = 0; set_seconds = 0;
    alarm_we = 0; alarm_idx = 0; alarm_hours = 0; alarm_minutes = 0;
    alarm_enable = 0; snooze = 0; dismiss = 0;
    step(3);

    // Reset with out-of-range hours_init, then first prescaler period
    reset = 1'b0;
    exp_time(0, 0, 0, 0, "rst_hr30");
    exp_tick(0, 0, "rst_tick");
    exp_act(0, 0, "rst_active");
    exp_flash(0, 0, "rst_flash");
    exp_tick(2, 0, "tick_pre");
    exp_tick(3, 1, "tick_first");
    exp_time(4, 0, 0, 1, "first_sec");
    step(5);

    hours_init = 5'd5; reset = 1'b1;
    exp_time(0, 5, 0, 0, "rst_hr5");
    step(2);
    reset = 1'b0;
    step(1);

    // Rollover 23:59:58 -> 00:00:00
    do_set(23, 59, 58);
    exp_time(0, 23, 59, 58, "roll_load");
    exp_tick(2, 0, "roll_tick_lo");
    exp_tick(3, 1, "roll_tick_hi");
    exp_time(4, 23, 59, 59, "roll_59");
    exp_tick(7, 1, "roll_tick2");
    exp_time(8, 0, 0, 0, "rollover");
    step(9);

    // Out-of-range set ignored, prescaler keeps running
    do_set(10, 20, 30);
    set_hours = 5'd1; set_minutes = 6'd60; set_seconds = 6'd0; set_en = 1'b1;
    step(1);
    set_en = 1'b0;
    exp_time(0, 10, 20, 30, "badset_min");
    exp_tick(2, 1, "badset_presc");
    exp_time(3, 10, 20, 31, "badset_count");
    step(4);

    // Set on the tick cycle wins and suppresses sec_tick
    do_set(12, 0, 0);
    step(3);
    exp_tick(0, 0, "set_beats_tick");
    do_set(12, 34, 56);
    exp_time(0, 12, 34, 56, "set_on_tick");
    exp_tick(3, 1, "set_tick_after");
    exp_time(4, 12, 34, 57, "set_count_after");
    step(5);

    // Alarm ch1 at 07:30, rings 3 seconds, flash 1,1,0,0,1
    wr_alarm(1, 7, 30, 1'b1);
    do_set(7, 29, 59);
    exp_act(4, 0, "alm_pre");
    exp_act(5, 2, "alm_ring");
    exp_flash(5, 1, "flash0");
    exp_flash(6, 1, "flash1");
    exp_flash(7, 0, "flash2");
    exp_flash(8, 0, "flash3");
    exp_flash(9, 1, "flash4");
    exp_act(15, 2, "alm_last");
    exp_act(16, 0, "alm_auto_stop");
    exp_flash(16, 0, "flash_off");
    exp_time(16, 7, 30, 3, "alm_stop_time");
    step(18);

    // Snooze at 07:30:01, rings again at 07:35:00, dismiss
    do_set(7, 29, 59);
    step(8);
    exp_act(0, 2, "snz_before");
    snooze = 1'b1; step(1); snooze = 1'b0;
    exp_act(0, 0, "snoozed");
    exp_flash(0, 0, "snoozed_flash");
    do_set(7, 34, 59);
    exp_act(4, 0, "snz_pre");
    exp_act(5, 2, "snz_rering");
    step(6);
    dismiss = 1'b1; step(1); dismiss = 1'b0;
    exp_act(0, 0, "dismissed");
    step(2);

    // Snooze across midnight: 23:58 + 5 -> 00:03
    wr_alarm(0, 23, 58, 1'b1);
    do_set(23, 57, 59);
    exp_act(5, 1, "wrap_ring");
    step(8);
    snooze = 1'b1; step(1); snooze = 1'b0;
    exp_act(0, 0, "wrap_snoozed");
    do_set(0, 2, 59);
    exp_act(4, 0, "wrap_pre");
    exp_act(5, 1, "wrap_rering");
    step(6);
    dismiss = 1'b1; step(1); dismiss = 1'b0;
    exp_act(0, 0, "wrap_dismissed");
    step(2);

    // Snooze and dismiss together: channel must go IDLE, not SNOOZED
    do_set(23, 57, 59);
    step(6);
    exp_act(0, 1, "sd_ring");
    snooze = 1'b1; dismiss = 1'b1; step(1); snooze = 1'b0; dismiss = 1'b0;
    exp_act(0, 0, "sd_idle");
    do_set(0, 2, 59);
    exp_act(5, 0, "sd_no_rering");
    step(6);

    // Alarm write to a ringing channel returns it to IDLE
    do_set(23, 57, 59);
    step(6);
    exp_act(0, 1, "we_ring");
    wr_alarm(0, 23, 58, 1'b1);
    exp_act(0, 0, "we_idle");
    step(2);

    // Invalid alarm write ignored, then reset mid-ring clears everything
    wr_alarm(1, 7, 60, 1'b0);
    do_set(7, 29, 59);
    exp_act(5, 2, "badwr_ignored");
    step(6);
    hours_init = 5'd5; reset = 1'b1;
    exp_time(0, 5, 0, 0, "rr_time");
    exp_act(0, 0, "rr_active");
    exp_flash(0, 0, "rr_flash");
    exp_tick(0, 0, "rr_tick");
    step(1);
    reset = 1'b0;
    do_set(7, 29, 59);
    exp_act(5, 0, "rr_alarm_cleared");
    step(7);

    done = 1'b1;
  end

endmodule
